mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 28 ++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Two-requester memory arbiter bus: instruction cache (r0), data cache (r1)
// and the four-bank memory side. The slave modport is the arbiter's view.
interface mem_arbiter_if;
  logic [15:0] r0_addr, r0_data_in, r0_data_out;
  logic        r0_rd, r0_wr, r0_lock, r0_grant, r0_stall, r0_rvalid, r0_err;
  logic [15:0] r1_addr, r1_data_in, r1_data_out;
  logic        r1_rd, r1_wr, r1_lock, r1_grant, r1_stall, r1_rvalid, r1_err;
  logic [15:0] m_addr, m_data_in, m_data_out;
  logic        m_rd, m_wr, m_stall, m_err;

  modport slave (
    input  r0_addr, r0_data_in, r0_rd, r0_wr, r0_lock,
    input  r1_addr, r1_data_in, r1_rd, r1_wr, r1_lock,
    input  m_data_out, m_stall, m_err,
    output r0_grant, r0_stall, r0_data_out, r0_rvalid, r0_err,
    output r1_grant, r1_stall, r1_data_out, r1_rvalid, r1_err,
    output m_addr, m_data_in, m_rd, m_wr
  );

  modport master (
    output r0_addr, r0_data_in, r0_rd, r0_wr, r0_lock,
    output r1_addr, r1_data_in, r1_rd, r1_wr, r1_lock,
    output m_data_out, m_stall, m_err,
    input  r0_grant, r0_stall, r0_data_out, r0_rvalid, r0_err,
    input  r1_grant, r1_stall, r1_data_out, r1_rvalid, r1_err,
    input  m_addr, m_data_in, m_rd, m_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter with burst lock and RD_LAT-deep read-return tracking.
// Define MEM_ARB_RR_EN for round-robin tie-break; default is fixed priority to port 1.
module mem_arbiter #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic [1:0]        r_state;
  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_id;

  logic w_req0, w_req1, w_ill0, w_ill1;
  logic w_win, w_tie_win, w_gnt0, w_gnt1, w_any;
  logic w_rd_g, w_wr_g, w_ill_g, w_lock_g, w_acc, w_rd_acc;
  logic w_busy0, w_busy1, w_rv;
  logic [15:0] w_addr_g, w_din_g;

  assign w_req0 = bus.r0_rd | bus.r0_wr;
  assign w_req1 = bus.r1_rd | bus.r1_wr;
  assign w_ill0 = bus.r0_rd & bus.r0_wr;
  assign w_ill1 = bus.r1_rd & bus.r1_wr;

`ifdef MEM_ARB_RR_EN
  logic r_last;
  assign w_tie_win = ~r_last;
  always_ff @(posedge clk) begin
    if (rst)                    r_last <= 1'b1;
    else if (w_acc && !w_ill_g) r_last <= w_win;
  end
`else
  assign w_tie_win = 1'b1;
`endif

  always_comb begin
    w_win = 1'b0;
    case (r_state)
      S_OWN0:  w_win = 1'b0;
      S_OWN1:  w_win = 1'b1;
      default: w_win = (w_req0 && w_req1) ? w_tie_win : w_req1;
    endcase
  end

  assign w_gnt0   = w_req0 & ~w_win & ~rst;
  assign w_gnt1   = w_req1 &  w_win & ~rst;
  assign w_any    = w_gnt0 | w_gnt1;
  assign w_rd_g   = w_win ? bus.r1_rd      : bus.r0_rd;
  assign w_wr_g   = w_win ? bus.r1_wr      : bus.r0_wr;
  assign w_ill_g  = w_win ? w_ill1         : w_ill0;
  assign w_lock_g = w_win ? bus.r1_lock    : bus.r0_lock;
  assign w_addr_g = w_win ? bus.r1_addr    : bus.r0_addr;
  assign w_din_g  = w_win ? bus.r1_data_in : bus.r0_data_in;
  assign w_acc    = w_any & ~bus.m_stall;
  assign w_rd_acc = w_acc & w_rd_g & ~w_ill_g;

  assign bus.m_addr    = w_any ? w_addr_g : '0;
  assign bus.m_data_in = w_any ? w_din_g  : '0;
  assign bus.m_rd      = w_any & w_rd_g & ~w_ill_g;
  assign bus.m_wr      = w_any & w_wr_g & ~w_ill_g;

  assign bus.r0_grant = w_gnt0;
  assign bus.r1_grant = w_gnt1;
  assign bus.r0_stall = w_req0 & (~w_gnt0 | bus.m_stall) & ~rst;
  assign bus.r1_stall = w_req1 & (~w_gnt1 | bus.m_stall) & ~rst;
  assign bus.r0_err   = w_gnt0 & (bus.m_err | w_ill0);
  assign bus.r1_err   = w_gnt1 & (bus.m_err | w_ill1);

  // The last stage returns its data this cycle, so it no longer pins ownership.
  always_comb begin
    w_busy0 = 1'b0;
    w_busy1 = 1'b0;
    for (int unsigned i = 0; i + 1 < RD_LAT; i++) begin
      if (r_vld[i] && !r_id[i]) w_busy0 = 1'b1;
      if (r_vld[i] &&  r_id[i]) w_busy1 = 1'b1;
    end
    if (w_rd_acc && !w_win) w_busy0 = 1'b1;
    if (w_rd_acc &&  w_win) w_busy1 = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_any && w_lock_g && !w_ill_g) r_state <= w_win ? S_OWN1 : S_OWN0;
        S_OWN0:  if (!bus.r0_lock && !w_busy0) r_state <= S_IDLE;
        S_OWN1:  if (!bus.r1_lock && !w_busy1) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_id  <= '0;
    end else begin
      r_vld[0] <= w_rd_acc;
      r_id[0]  <= w_win;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
      end
    end
  end

  assign w_rv            = r_vld[RD_LAT-1] & ~rst;
  assign bus.r0_rvalid   = w_rv & ~r_id[RD_LAT-1];
  assign bus.r1_rvalid   = w_rv &  r_id[RD_LAT-1];
  assign bus.r0_data_out = bus.r0_rvalid ? bus.m_data_out : '0;
  assign bus.r1_data_out = bus.r1_rvalid ? bus.m_data_out : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: read returns are checked by a queue-based
// scoreboard/monitor; grant/stall/error behaviour is checked inline.
module tb_mem_arbiter;
  localparam int unsigned RD_LAT = 2;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;
  int   wr_acc;

  typedef struct {
    logic        port;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] wmem [int];
  logic [15:0] md [RD_LAT];
  logic        tie_exp [3];

  mem_arbiter_if bus ();

  mem_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] exp_rd(input logic [15:0] a);
    if (wmem.exists(int'(a))) return wmem[int'(a)];
    if (a == 16'h0010) return 16'h1234;
    return a ^ 16'hA5A5;
  endfunction

  // Memory model: fixed read latency, writes land on accepted m_wr.
  always @(posedge clk) begin
    md[0] <= (bus.m_rd && !bus.m_stall) ? exp_rd(bus.m_addr) : 16'h0000;
    for (int i = 1; i < int'(RD_LAT); i++) md[i] <= md[i-1];
    if (bus.m_wr && !bus.m_stall) begin
      wmem[int'(bus.m_addr)] = bus.m_data_in;
      wr_acc = wr_acc + 1;
    end
  end
  assign bus.m_data_out = md[RD_LAT-1];

  task automatic chk(input string nm, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic p, input logic [15:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    e.cyc  = cyc + int'(RD_LAT);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.r0_addr = '0; bus.r0_data_in = '0; bus.r0_rd = 0; bus.r0_wr = 0; bus.r0_lock = 0;
    bus.r1_addr = '0; bus.r1_data_in = '0; bus.r1_rd = 0; bus.r1_wr = 0; bus.r1_lock = 0;
    bus.m_stall = 0; bus.m_err = 0;
  endtask

  // Scoreboard monitor: every rvalid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.r0_rvalid || bus.r1_rvalid) begin
        if (sb.size() == 0) begin
          chk("rvalid_unexpected", int'({bus.r1_rvalid, bus.r0_rvalid}), 0);
        end else begin
          mon_e = sb.pop_front();
          chk("rv_port", int'({bus.r1_rvalid, bus.r0_rvalid}), mon_e.port ? 2 : 1);
          chk("rv_data", int'(mon_e.port ? bus.r1_data_out : bus.r0_data_out), int'(mon_e.data));
          chk("rv_other_zero", int'(mon_e.port ? bus.r0_data_out : bus.r1_data_out), 0);
          chk("rv_cycle", cyc, mon_e.cyc);
        end
      end else begin
        chk("dout_idle", int'({bus.r1_data_out, bus.r0_data_out}), 0);
      end
    end
  end

  initial begin
    logic [15:0] a0, a1;
    int wa;
`ifdef MEM_ARB_RR_EN
    tie_exp[0] = 0; tie_exp[1] = 1; tie_exp[2] = 0;
`else
    tie_exp[0] = 1; tie_exp[1] = 1; tie_exp[2] = 1;
`endif
    clk = 0; cyc = 0; errors = 0; checks = 0; wr_acc = 0;
    rst = 1;
    clear_inputs();
    bus.r0_rd = 1;
    tick();
    mid();
    chk("rst_r0_grant", int'(bus.r0_grant), 0);
    chk("rst_r0_stall", int'(bus.r0_stall), 0);
    chk("rst_m_rd", int'(bus.m_rd), 0);
    chk("rst_r0_rvalid", int'(bus.r0_rvalid), 0);
    tick();
    rst = 0;
    clear_inputs();

    // Single read from the instruction cache
    bus.r0_rd = 1; bus.r0_addr = 16'h0010;
    mid();
    chk("rd_r0_grant", int'(bus.r0_grant), 1);
    chk("rd_r0_stall", int'(bus.r0_stall), 0);
    chk("rd_m_rd", int'(bus.m_rd), 1);
    chk("rd_m_addr", int'(bus.m_addr), 16'h0010);
    chk("rd_r1_grant", int'(bus.r1_grant), 0);
    push(0, 16'h1234);
    tick();
    clear_inputs();

    // Back-to-back reads from the data cache
    for (int k = 0; k < 3; k++) begin
      bus.r1_rd = 1; bus.r1_addr = 16'h0020 + 16'(k);
      mid();
      chk("b2b_r1_grant", int'(bus.r1_grant), 1);
      push(1, exp_rd(16'h0020 + 16'(k)));
      tick();
    end
    clear_inputs();
    repeat (RD_LAT + 1) tick();

    // Ties in IDLE after a fresh reset
    rst = 1; tick(); rst = 0;
    a0 = 16'h0030; a1 = 16'h0031;
    for (int k = 0; k < 3; k++) begin
      bus.r0_rd = 1; bus.r0_addr = a0;
      bus.r1_rd = 1; bus.r1_addr = a1;
      mid();
      chk("tie_r0_grant", int'(bus.r0_grant), int'(!tie_exp[k]));
      chk("tie_r1_grant", int'(bus.r1_grant), int'(tie_exp[k]));
      if (tie_exp[k]) begin push(1, exp_rd(a1)); a1 = a1 + 16'd2; end
      else            begin push(0, exp_rd(a0)); a0 = a0 + 16'd2; end
      tick();
    end
    clear_inputs();

    // Locked write burst from r1 while r0 waits
    bus.r0_rd = 1; bus.r0_addr = 16'h0040;
    for (int k = 0; k < 4; k++) begin
      bus.r1_wr = 1; bus.r1_lock = 1;
      bus.r1_addr = 16'h0100 + 16'(k); bus.r1_data_in = 16'hBEE0 + 16'(k);
      mid();
      chk("burst_r1_grant", int'(bus.r1_grant), 1);
      chk("burst_r0_stall", int'(bus.r0_stall), 1);
      chk("burst_m_wr", int'(bus.m_wr), 1);
      chk("burst_m_addr", int'(bus.m_addr), 16'h0100 + k);
      chk("burst_m_data", int'(bus.m_data_in), 16'hBEE0 + k);
      tick();
    end
    bus.r1_wr = 0; bus.r1_lock = 0;
    mid();
    chk("unlock_r0_grant", int'(bus.r0_grant), 0);
    chk("unlock_r0_stall", int'(bus.r0_stall), 1);
    tick();
    mid();
    chk("after_r0_grant", int'(bus.r0_grant), 1);
    push(0, 16'hA5E5);
    tick();
    clear_inputs();
    bus.r0_rd = 1; bus.r0_addr = 16'h0102;
    mid();
    chk("readback_grant", int'(bus.r0_grant), 1);
    push(0, 16'hBEE2);
    tick();
    clear_inputs();

    // Ownership held until the owner's read has returned
    bus.r0_rd = 1; bus.r0_lock = 1; bus.r0_addr = 16'h0080;
    mid();
    chk("own_r0_grant", int'(bus.r0_grant), 1);
    push(0, exp_rd(16'h0080));
    tick();
    clear_inputs();
    bus.r1_rd = 1; bus.r1_addr = 16'h0081;
    mid(); chk("inflight_r1_stall_a", int'(bus.r1_stall), 1); tick();
    mid(); chk("inflight_r1_stall_b", int'(bus.r1_stall), 1); tick();
    mid();
    chk("release_r1_grant", int'(bus.r1_grant), 1);
    push(1, exp_rd(16'h0081));
    tick();
    clear_inputs();

    // Memory stall during a write
    wa = wr_acc;
    bus.r0_wr = 1; bus.r0_addr = 16'h0050; bus.r0_data_in = 16'h5555; bus.m_stall = 1;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("mstall_r0_stall", int'(bus.r0_stall), 1);
      chk("mstall_r0_grant", int'(bus.r0_grant), 1);
      tick();
    end
    bus.m_stall = 0;
    mid();
    chk("mstall_release", int'(bus.r0_stall), 0);
    tick();
    clear_inputs();
    mid();
    chk("mstall_one_write", wr_acc - wa, 1);
    tick();
    bus.r0_rd = 1; bus.r0_addr = 16'h0050;
    mid();
    push(0, 16'h5555);
    tick();
    clear_inputs();

    // Illegal rd+wr with lock: error, no memory strobe, no ownership
    bus.r1_rd = 1; bus.r1_wr = 1; bus.r1_lock = 1; bus.r1_addr = 16'h0060;
    mid();
    chk("ill_r1_err", int'(bus.r1_err), 1);
    chk("ill_m_rd_wr", int'({bus.m_rd, bus.m_wr}), 0);
    chk("ill_r1_stall", int'(bus.r1_stall), 0);
    tick();
    clear_inputs();
    bus.r0_rd = 1; bus.r0_addr = 16'h0061;
    mid();
    chk("ill_no_own", int'(bus.r0_grant), 1);
    push(0, exp_rd(16'h0061));
    tick();
    clear_inputs();

    // Memory error passthrough
    bus.r0_wr = 1; bus.r0_addr = 16'h0070; bus.m_err = 1;
    mid();
    chk("merr_r0_err", int'(bus.r0_err), 1);
    chk("merr_r1_err", int'(bus.r1_err), 0);
    tick();
    clear_inputs();

    // Lock without a request is ignored
    bus.r0_lock = 1;
    tick();
    bus.r1_rd = 1; bus.r1_addr = 16'h0090;
    mid();
    chk("lock_noreq_r1_grant", int'(bus.r1_grant), 1);
    push(1, exp_rd(16'h0090));
    tick();
    clear_inputs();
    repeat (RD_LAT + 1) tick();

    // Reset with a locked read in flight
    bus.r0_rd = 1; bus.r0_lock = 1; bus.r0_addr = 16'h0010;
    mid();
    chk("rstfl_r0_grant", int'(bus.r0_grant), 1);
    tick();
    rst = 1;
    clear_inputs();
    tick();
    rst = 0;
    mid();
    chk("rstfl_r0_rvalid", int'(bus.r0_rvalid), 0);
    chk("rstfl_r0_dout", int'(bus.r0_data_out), 0);
    chk("rstfl_grants", int'({bus.r1_grant, bus.r0_grant}), 0);
    chk("rstfl_m_bus", int'({bus.m_rd, bus.m_wr, bus.m_addr}), 0);
    tick();
    bus.r1_rd = 1; bus.r1_addr = 16'h0020;
    mid();
    chk("rstfl_idle_r1_grant", int'(bus.r1_grant), 1);
    chk("rstfl_idle_r1_stall", int'(bus.r1_stall), 0);
    push(1, exp_rd(16'h0020));
    tick();
    clear_inputs();
    repeat (RD_LAT + 2) tick();
    mid();
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
